// File: rtl/pong_score_ctrl.sv
// pong_score_ctrl
// Game-flow controller for a two-player pong. It samples the ball x position
// once per frame, detects goals at the left/right walls, keeps both scores and
// sequences IDLE -> SERVE -> PLAY -> (SERVE | GAMEOVER). All outputs are
// registered.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   frame_tick  one-cycle pulse per frame
//   ball_x      ball left edge x, valid with frame_tick
//   start_btn   start/restart button level (already synchronised)
//   p1_score    left player score
//   p2_score    right player score
//   state       0=IDLE 1=SERVE 2=PLAY 3=GAMEOVER
//   ball_run    animation stage may move the ball (PLAY only)
//   ball_reset  one-cycle recentre pulse
//   serve_dir   0 = serve toward right, 1 = toward left
//   winner      0 none, 1 p1, 2 p2
module pong_score_ctrl #(
  parameter int H_SCREEN     = 640,
  parameter int BORDER       = 10,
  parameter int BALL_SIZE    = 10,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [9:0] ball_x,
  input  logic       start_btn,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] state,
  output logic       ball_run,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [1:0] winner
);

  localparam int          CNT_W   = $clog2(SERVE_FRAMES + 1);
  localparam logic [10:0] GOAL_L  = 11'(BORDER);
  localparam logic [10:0] GOAL_R  = 11'(H_SCREEN - BORDER - BALL_SIZE);
  localparam logic [3:0]  WIN_VAL = 4'(WIN_SCORE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_PLAY  = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t             state_q;
  logic [3:0]         p1_q, p2_q;
  logic [1:0]         winner_q;
  logic               run_q, rst_ball_q, dir_q;
  logic               start_prev_q;
  logic [CNT_W-1:0]   cnt_q;

  logic        start_edge;
  logic [10:0] ball_x_ext;
  logic        goal_left, goal_right;
  logic [3:0]  p1_inc, p2_inc;

  assign start_edge = start_btn & ~start_prev_q;
  assign ball_x_ext = {1'b0, ball_x};
  assign goal_left  = (ball_x_ext <= GOAL_L);
  assign goal_right = (ball_x_ext >= GOAL_R);
  assign p1_inc     = p1_q + 4'd1;
  assign p2_inc     = p2_q + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      p1_q         <= 4'd0;
      p2_q         <= 4'd0;
      winner_q     <= 2'd0;
      run_q        <= 1'b0;
      rst_ball_q   <= 1'b0;
      dir_q        <= 1'b0;
      cnt_q        <= '0;
      // Held high so a button already pressed during reset is not an edge.
      start_prev_q <= 1'b1;
    end else begin
      start_prev_q <= start_btn;
      rst_ball_q   <= 1'b0;
      case (state_q)
        // A new game starts from either idle or after a finished game; any
        // coincident frame_tick is not counted toward the serve delay.
        S_IDLE, S_OVER: begin
          if (start_edge) begin
            state_q    <= S_SERVE;
            p1_q       <= 4'd0;
            p2_q       <= 4'd0;
            winner_q   <= 2'd0;
            dir_q      <= 1'b0;
            cnt_q      <= CNT_W'(SERVE_FRAMES);
            rst_ball_q <= 1'b1;
            run_q      <= 1'b0;
          end
        end
        S_SERVE: begin
          if (frame_tick) begin
            if (cnt_q == CNT_W'(1)) begin
              state_q <= S_PLAY;
              run_q   <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
        end
        S_PLAY: begin
          if (frame_tick && (goal_left || goal_right)) begin
            run_q      <= 1'b0;
            rst_ball_q <= 1'b1;
            // Left wall wins when both tests hit; the conceding side receives.
            if (goal_left) begin
              p2_q  <= p2_inc;
              dir_q <= 1'b1;
              if (p2_inc == WIN_VAL) begin
                state_q  <= S_OVER;
                winner_q <= 2'd2;
              end else begin
                state_q <= S_SERVE;
                cnt_q   <= CNT_W'(SERVE_FRAMES);
              end
            end else begin
              p1_q  <= p1_inc;
              dir_q <= 1'b0;
              if (p1_inc == WIN_VAL) begin
                state_q  <= S_OVER;
                winner_q <= 2'd1;
              end else begin
                state_q <= S_SERVE;
                cnt_q   <= CNT_W'(SERVE_FRAMES);
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign p1_score   = p1_q;
  assign p2_score   = p2_q;
  assign state      = state_q;
  assign ball_run   = run_q;
  assign ball_reset = rst_ball_q;
  assign serve_dir  = dir_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_pong_score_ctrl.sv
// Directed bench for pong_score_ctrl. Two instances share all inputs:
// dut_a uses WIN_SCORE=9, dut_b uses WIN_SCORE=2; both use SERVE_FRAMES=3.
module tb_pong_score_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic [9:0] ball_x;
  logic       start_btn;

  logic [3:0] a_p1, a_p2, b_p1, b_p2;
  logic [1:0] a_st, b_st, a_win, b_win;
  logic       a_run, a_br, a_dir, b_run, b_br, b_dir;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pong_score_ctrl #(.WIN_SCORE(9), .SERVE_FRAMES(3)) dut_a (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .ball_x(ball_x),
    .start_btn(start_btn), .p1_score(a_p1), .p2_score(a_p2), .state(a_st),
    .ball_run(a_run), .ball_reset(a_br), .serve_dir(a_dir), .winner(a_win)
  );

  pong_score_ctrl #(.WIN_SCORE(2), .SERVE_FRAMES(3)) dut_b (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .ball_x(ball_x),
    .start_btn(start_btn), .p1_score(b_p1), .p2_score(b_p2), .state(b_st),
    .ball_run(b_run), .ball_reset(b_br), .serve_dir(b_dir), .winner(b_win)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are stable 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int x);
    ball_x     = 10'(x);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic press();
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
  endtask

  task automatic serve3();
    tick(300);
    tick(300);
    tick(300);
  endtask

  initial begin
    reset      = 1'b1;
    start_btn  = 1'b1;
    frame_tick = 1'b0;
    ball_x     = 10'd300;
    step();
    step();
    chk("rst_state",  a_st,  0);
    chk("rst_p1",     a_p1,  0);
    chk("rst_p2",     a_p2,  0);
    chk("rst_winner", a_win, 0);
    chk("rst_run",    a_run, 0);
    chk("rst_br",     a_br,  0);
    chk("rst_dir",    a_dir, 0);

    // Button held through reset must not start a game.
    reset = 1'b0;
    step(); step(); step();
    chk("held_no_start", a_st, 0);
    start_btn = 1'b0;
    step();
    chk("release_idle", a_st, 0);
    press();
    chk("start_state", a_st,  1);
    chk("start_br",    a_br,  1);
    chk("start_run",   a_run, 0);
    step();
    chk("br_one_cycle", a_br, 0);

    // Serve delay of exactly 3 ticks.
    tick(300);
    chk("serve_t1", a_st, 1);
    tick(300);
    chk("serve_t2_state", a_st,  1);
    chk("serve_t2_run",   a_run, 0);
    tick(300);
    chk("serve_t3_state", a_st,  2);
    chk("serve_t3_run",   a_run, 1);

    // No tick with goal position, and tick in mid-field: nothing happens.
    ball_x = 10'd5;
    step(); step();
    chk("notick_state", a_st, 2);
    chk("notick_p2",    a_p2, 0);
    tick(300);
    chk("mid_state", a_st, 2);
    chk("mid_p1",    a_p1, 0);

    // Left goal at the boundary.
    tick(10);
    chk("gl_p2",    a_p2,  1);
    chk("gl_dir",   a_dir, 1);
    chk("gl_state", a_st,  1);
    chk("gl_br",    a_br,  1);
    chk("gl_run",   a_run, 0);
    step();
    chk("gl_br_low", a_br, 0);

    // Right goal at the boundary.
    serve3();
    tick(620);
    chk("gr_p1",    a_p1,  1);
    chk("gr_dir",   a_dir, 0);
    chk("gr_state", a_st,  1);

    // Just inside both walls: no goal.
    serve3();
    tick(11);
    chk("in_l_state", a_st, 2);
    tick(619);
    chk("in_r_state", a_st, 2);
    chk("in_r_p1",    a_p1, 1);
    chk("in_r_p2",    a_p2, 1);

    tick(620);
    serve3();
    tick(1023);
    chk("s31_p1",    a_p1, 3);
    chk("s31_p2",    a_p2, 1);
    chk("s31_state", a_st, 1);

    // Reset mid-serve.
    tick(300);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_state", a_st, 0);
    chk("mid_rst_p1",    a_p1, 0);
    chk("mid_rst_p2",    a_p2, 0);
    tick(300);
    chk("idle_tick", a_st, 0);

    // Start coincident with a tick: tick is not counted.
    start_btn  = 1'b1;
    frame_tick = 1'b1;
    step();
    start_btn  = 1'b0;
    frame_tick = 1'b0;
    chk("sim_start_state", a_st, 1);
    tick(300);
    tick(300);
    chk("sim_t2_state", a_st, 1);
    tick(300);
    chk("sim_t3_state", a_st, 2);
    chk("b_play_state", b_st, 2);

    // WIN_SCORE=2 game on dut_b: p1 wins.
    tick(620);
    chk("w_p1_first", b_p1, 1);
    serve3();
    tick(620);
    chk("w_state",  b_st,  3);
    chk("w_winner", b_win, 1);
    chk("w_p1",     b_p1,  2);
    chk("w_run",    b_run, 0);
    chk("w_br",     b_br,  1);
    step();
    chk("w_br_low", b_br, 0);
    tick(0);
    chk("over_hold_p2", b_p2, 0);
    chk("over_hold_st", b_st, 3);
    press();
    chk("restart_state",  b_st,  1);
    chk("restart_p1",     b_p1,  0);
    chk("restart_winner", b_win, 0);
    chk("restart_br",     b_br,  1);

    // p2 wins with left goals.
    serve3();
    tick(0);
    chk("p2w_first", b_p2, 1);
    serve3();
    tick(10);
    chk("p2w_state",  b_st,  3);
    chk("p2w_winner", b_win, 2);
    chk("p2w_dir",    b_dir, 1);
    chk("p2w_p2",     b_p2,  2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_score_ctrl.md
Name: pong_score_ctrl

Overview:
Game-flow controller that sits downstream of the ball/paddle draw-and-animate stage. Once per frame it samples the ball's x position and detects goals (ball reaching the left or right wall). It keeps both players' scores, sequences idle/serve/play/game-over, and drives the ball-enable, ball-recentre and serve-direction controls back to the animation stage. All outputs are registered on clk; the score digits are consumed by a later overlay stage.

Parameters:
H_SCREEN, 640, visible width in pixels
BORDER, 10, wall thickness in pixels
BALL_SIZE, 10, ball edge length in pixels
WIN_SCORE, 9, score that ends the game (1..15)
SERVE_FRAMES, 60, frames the ball is held before each serve (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse per frame (end of visible area)
ball_x  in  10  ball left edge x, valid at frame_tick
start_btn  in  1  start/restart button, level, already synchronised
p1_score  out  4  left player score
p2_score  out  4  right player score
state  out  2  0=IDLE 1=SERVE 2=PLAY 3=GAMEOVER
ball_run  out  1  1 = animation stage may move ball
ball_reset  out  1  one-cycle pulse: recentre ball
serve_dir  out  1  0 = serve toward right, 1 = toward left
winner  out  2  0 none, 1 p1, 2 p2

Behaviour:
- Reset values:
  - state=IDLE; scores=0; winner=0; ball_run=0; ball_reset=0; serve_dir=0; serve counter=0.
  - start_prev=1, so a button held through reset does not start a game.
- start_edge = start_btn & ~start_prev. start_prev is updated every cycle.
- ball_run=1 only in PLAY (registered, same cycle as state). ball_reset defaults to 0 every cycle.
- Goal checks happen only in PLAY on frame_tick:
  - goal_left = ball_x <= BORDER.
  - goal_right = ball_x >= H_SCREEN-BORDER-BALL_SIZE.
  - If both are true, goal_left takes priority.
  - Compares use 11-bit unsigned arithmetic.
- IDLE:
  - start_edge -> SERVE; scores=0; winner=0; serve_dir=0; counter=SERVE_FRAMES; ball_reset=1.
  - frame_tick is ignored.
- SERVE:
  - Each frame_tick decrements the counter.
  - The tick at which counter==1 moves to PLAY, so exactly SERVE_FRAMES ticks are spent here.
  - start_btn is ignored.
- PLAY:
  - goal_left: p2_score+1, serve_dir=1 (toward the conceding p1).
  - goal_right: p1_score+1, serve_dir=0.
  - If the incremented score == WIN_SCORE -> GAMEOVER, winner set (1 or 2), ball_reset=1.
  - Otherwise -> SERVE, counter=SERVE_FRAMES, ball_reset=1.
  - No goal: stay in PLAY. start_btn is ignored.
- GAMEOVER:
  - Scores and winner are held.
  - start_edge -> SERVE, same actions as IDLE->SERVE (clears scores and winner).
- Latency: every effect of a frame_tick or start_edge is visible on outputs the next clk edge. ball_reset is high for exactly that one cycle.
- Simultaneous start_edge and frame_tick in IDLE/GAMEOVER: start is taken; the tick does not count toward the serve delay.
- Only one goal is scored per frame_tick. After a goal, no further scoring occurs until the next PLAY.
- Scores never exceed WIN_SCORE, so there is no wrap-around.
- reset asserted in any state returns all outputs to reset values on the next edge.

Test Plan:
- Reset with start_btn held high, release, then press -> no start while held. After the press: next cycle state=1, ball_reset=1 for 1 cycle, ball_run=0.
- SERVE_FRAMES=3, start, then 3 frame_ticks -> state=2 and ball_run=1 one cycle after the 3rd tick, not before.
- In PLAY, frame_tick with ball_x=10 -> p2_score 0->1, serve_dir=1, state=1, ball_reset pulse. frame_tick with ball_x=620 -> p1_score+1, serve_dir=0.
- In PLAY, ball_x=300 on frame_tick, and ball_x=5 with no frame_tick -> no score change, state stays 2.
- WIN_SCORE=2, score p1 twice -> after the second goal state=3, winner=1, p1_score=2, ball_run=0. Then press start -> state=1, scores=0, winner=0.
- Assert reset mid-SERVE with scores 3:1 -> next edge state=0, scores 0, counter cleared. A frame_tick in IDLE leaves state unchanged.
